// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter fed from a show-ahead FIFO, with an internal baud divider.
// Frames run back-to-back while the FIFO has data.
module uart_tx_cfg #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 empty_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 rd_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic                 tx_out
);
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb_first
    $error("uart_tx_cfg: MSB_FIRST must be 0 or 1");
  end
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        clk_q, clk_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, sh_next;
  logic                 par_q, par_d, tx_q, tx_d, busy_q, busy_d, rd_q, done_q, done_d;
  logic                 load, bit_end, last_stop, out_bit;
  assign bit_end   = clk_q == CW'(CLKS_PER_BIT - 1);
  assign last_stop = stop_q == 1'(STOP_BITS - 1);
  assign out_bit   = (MSB_FIRST != 0) ? sh_q[DATA_BITS-1] : sh_q[0];
  assign sh_next   = (MSB_FIRST != 0) ? sh_q << 1 : sh_q >> 1;
  always_comb begin
    state_d = state_q;
    clk_d   = (state_q == IDLE || bit_end) ? '0 : clk_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = !empty_i;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = out_bit;
        sh_d    = sh_next;
      end
      DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? PAR : STOP;
          tx_d    = (PARITY != 0) ? par_q : 1'b1;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
          tx_d  = out_bit;
          sh_d  = sh_next;
        end
      end
      PAR: if (bit_end) begin
        state_d = STOP;
        tx_d    = 1'b1;
        stop_d  = 1'b0;
      end
      STOP: if (bit_end) begin
        if (!last_stop) stop_d = 1'b1;
        else if (empty_i) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // The load path is shared by the idle pickup and the back-to-back pickup at the end of a stop bit.
    if (load) begin
      state_d = START;
      clk_d   = '0;
      sh_d    = tx_data_i;
      par_d   = (^tx_data_i) ^ (PARITY == 2);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
  end
  // frame_done_o is registered, so it is raised on the edge that enters the final stop cycle.
  assign done_d = state_d == STOP && clk_d == CW'(CLKS_PER_BIT - 1) && stop_d == 1'(STOP_BITS - 1);
  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q <= IDLE;
      clk_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_q   <= clk_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_q    <= load;
      done_q  <= done_d;
    end
  end
  assign rd_o         = rd_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign tx_out       = tx_q;
endmodule
